// File: rtl/cache_pkg.sv
// Shared definitions for the cache management unit and the 2-way data cache.
// Holds the address split (tag / index / line offset), line geometry, the
// CMU state encoding and the size/sign (u_b_h_w) codes passed to the cache.
package cache_pkg;

  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned TAG_WIDTH   = 23;
  localparam int unsigned LINE_WORDS  = 4;
  localparam int unsigned OFFSET_BITS = 4;

  localparam int unsigned WORD_BITS   = $clog2(LINE_WORDS);
  localparam int unsigned IDX_LSB     = OFFSET_BITS;                        // addr[4]
  localparam int unsigned TAG_LSB     = ADDR_WIDTH - TAG_WIDTH;             // addr[9]
  localparam int unsigned IDX_WIDTH   = TAG_LSB - IDX_LSB;                  // 5 bits
  localparam int unsigned LINE_WIDTH  = ADDR_WIDTH - OFFSET_BITS;           // tag + index

  typedef enum logic [1:0] {
    S_IDLE,
    S_BACK,
    S_FILL,
    S_WAIT
  } state_e;

  // Size/sign codes understood by the cache; bit 2 selects zero-extension.
  typedef enum logic [2:0] {
    UBHW_B  = 3'b000,
    UBHW_H  = 3'b001,
    UBHW_W  = 3'b010,
    UBHW_BU = 3'b100,
    UBHW_HU = 3'b101
  } ubhw_e;

  // Byte address of word w within the line identified by {tag, index}.
  function automatic logic [ADDR_WIDTH-1:0] line_word_addr(
      input logic [LINE_WIDTH-1:0] line,
      input logic [WORD_BITS-1:0]  w);
    return {line, w, 2'b00};
  endfunction

endpackage

// File: rtl/cache_cmu_if.sv
// Bus bundle around the CMU: CPU data port, cache control/status and the
// word-wide memory req/ack channel.
//   master : the CMU (drives cache/memory requests and the CPU stall/data)
//   slave  : the surroundings (CPU, cache array, memory)
interface cache_cmu_if;
  import cache_pkg::*;

  // CPU port
  logic                  cpu_req;
  logic                  cpu_wen;
  logic [2:0]            cpu_u_b_h_w;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [31:0]           cpu_din;
  logic [31:0]           cpu_dout;
  logic                  cpu_stall;

  // Cache port
  logic [ADDR_WIDTH-1:0] cache_addr;
  logic                  cache_load;
  logic                  cache_edit;
  logic                  cache_store;
  logic                  cache_invalid;
  logic [2:0]            cache_u_b_h_w;
  logic [31:0]           cache_din;
  logic                  cache_hit;
  logic [31:0]           cache_dout;
  logic                  cache_valid;
  logic                  cache_dirty;
  logic [TAG_WIDTH-1:0]  cache_tag;

  // Memory port
  logic                  mem_cs;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_dout;
  logic [31:0]           mem_din;
  logic                  mem_ack;

  modport master (
    input  cpu_req, cpu_wen, cpu_u_b_h_w, cpu_addr, cpu_din,
    output cpu_dout, cpu_stall,
    output cache_addr, cache_load, cache_edit, cache_store, cache_invalid,
    output cache_u_b_h_w, cache_din,
    input  cache_hit, cache_dout, cache_valid, cache_dirty, cache_tag,
    output mem_cs, mem_we, mem_addr, mem_dout,
    input  mem_din, mem_ack
  );

  modport slave (
    output cpu_req, cpu_wen, cpu_u_b_h_w, cpu_addr, cpu_din,
    input  cpu_dout, cpu_stall,
    input  cache_addr, cache_load, cache_edit, cache_store, cache_invalid,
    input  cache_u_b_h_w, cache_din,
    output cache_hit, cache_dout, cache_valid, cache_dirty, cache_tag,
    input  mem_cs, mem_we, mem_addr, mem_dout,
    output mem_din, mem_ack
  );

endinterface

// File: rtl/cache_cmu.sv
// Cache management unit for a 2-way set-associative write-back,
// write-allocate data cache.
//   clk : rising-edge clock (the cache itself updates on the falling edge)
//   rst : asynchronous active-low reset
//   bus : cache_cmu_if.master - CPU port, cache control/status, memory req/ack
// Hits complete combinationally in the same cycle. A miss stalls the CPU,
// writes back a dirty victim word by word, refills the line, spends one
// settle cycle, then lets the held CPU access replay as a hit.
module cache_cmu
  import cache_pkg::*;
(
  input logic         clk,
  input logic         rst,
  cache_cmu_if.master bus
);

  state_e                state_q, state_d;
  logic [WORD_BITS-1:0]  word_cnt_q, word_cnt_d;
  logic [LINE_WIDTH-1:0] req_line_q, req_line_d;   // latched missing line (addr[31:4])
  logic [TAG_WIDTH-1:0]  victim_tag_q, victim_tag_d;

  logic                  last_word;
  logic [ADDR_WIDTH-1:0] vaddr;
  logic [ADDR_WIDTH-1:0] faddr;

  assign last_word = (word_cnt_q == WORD_BITS'(LINE_WORDS - 1));
  assign vaddr = line_word_addr({victim_tag_q, req_line_q[IDX_WIDTH-1:0]}, word_cnt_q);
  assign faddr = line_word_addr(req_line_q, word_cnt_q);

  // Outputs that only follow the cache/memory data; kept out of the process
  // blocks so the cache's combinational read path does not form a loop.
  assign bus.cpu_dout      = rst ? bus.cache_dout : 32'h0;
  assign bus.mem_dout      = (rst && state_q == S_BACK) ? bus.cache_dout : 32'h0;
  assign bus.cache_invalid = 1'b0;

  // Address/strobe steering: depends only on state and CPU/memory inputs.
  always_comb begin
    bus.cache_addr    = '0;
    bus.cache_load    = 1'b0;
    bus.cache_store   = 1'b0;
    bus.cache_u_b_h_w = 3'b000;
    bus.cache_din     = 32'h0;
    bus.mem_cs        = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_addr      = '0;
    if (rst) begin
      case (state_q)
        S_IDLE: begin
          if (bus.cpu_req) begin
            bus.cache_addr    = bus.cpu_addr;
            bus.cache_u_b_h_w = bus.cpu_u_b_h_w;
            bus.cache_load    = ~bus.cpu_wen;
            bus.cache_din     = bus.cpu_din;
          end
        end
        S_BACK: begin
          bus.cache_addr    = vaddr;
          bus.cache_load    = 1'b1;
          bus.cache_u_b_h_w = UBHW_W;
          bus.mem_cs        = 1'b1;
          bus.mem_we        = 1'b1;
          bus.mem_addr      = vaddr;
        end
        S_FILL: begin
          bus.cache_addr    = faddr;
          bus.cache_u_b_h_w = UBHW_W;
          bus.mem_cs        = 1'b1;
          bus.mem_addr      = faddr;
          // Word is written into the cache in the same cycle memory returns it.
          if (bus.mem_ack) begin
            bus.cache_store = 1'b1;
            bus.cache_din   = bus.mem_din;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM next state, word counter, miss latching, stall and write-hit strobe.
  always_comb begin
    state_d        = state_q;
    word_cnt_d     = word_cnt_q;
    req_line_d     = req_line_q;
    victim_tag_d   = victim_tag_q;
    bus.cpu_stall  = 1'b0;
    bus.cache_edit = 1'b0;
    if (rst) begin
      case (state_q)
        S_IDLE: begin
          if (bus.cpu_req) begin
            bus.cache_edit = bus.cpu_wen & bus.cache_hit;
            if (!bus.cache_hit) begin
              bus.cpu_stall = 1'b1;
              req_line_d    = bus.cpu_addr[ADDR_WIDTH-1:OFFSET_BITS];
              victim_tag_d  = bus.cache_tag;
              word_cnt_d    = '0;
              state_d       = (bus.cache_valid && bus.cache_dirty) ? S_BACK : S_FILL;
            end
          end
        end
        S_BACK: begin
          bus.cpu_stall = 1'b1;
          if (bus.mem_ack) begin
            word_cnt_d = word_cnt_q + 1'b1;   // wraps to 0 on the last word
            if (last_word) state_d = S_FILL;
          end
        end
        S_FILL: begin
          bus.cpu_stall = 1'b1;
          if (bus.mem_ack) begin
            word_cnt_d = word_cnt_q + 1'b1;
            if (last_word) state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          bus.cpu_stall = 1'b1;
          state_d       = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      word_cnt_q   <= '0;
      req_line_q   <= '0;
      victim_tag_q <= '0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      req_line_q   <= req_line_d;
      victim_tag_q <= victim_tag_d;
    end
  end

endmodule

// File: tb/tb_cache_cmu.sv
// Bench for cache_cmu. Surrounds the CMU with a behavioural 2-way cache array
// (falling-edge writes, replacement by least recently filled/written way), a
// word memory with variable ack latency and a CPU driver. Expected memory
// traffic and read data come from an abstract model: a golden word memory
// plus, per set, a recency-ordered list of resident lines with dirty flags.
module tb_cache_cmu;
  import cache_pkg::*;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_txn_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  cache_cmu_if bus ();

  cache_cmu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit sb_off  = 1'b0;
  bit abort   = 1'b0;
  int fixed_lat = 2;   // 0 selects random 1..3 cycles per word
  int lat_sum   = 0;
  int n_acks    = 0;

  // Abstract reference state
  logic [31:0] gold [logic [31:0]];
  logic [31:0] mem_store [logic [31:0]];
  logic [31:0] res [32][$];          // per set: line base addresses, most recent first
  bit          ldirty [logic [31:0]];
  mem_txn_t    exp_mem [$];
  logic [31:0] exp_rd [$];

  // Environment cache array
  logic [22:0] ctag  [32][2];
  logic        cval  [32][2];
  logic        cdirty[32][2];
  logic [31:0] cdata [32][2][4];
  logic        clru  [32];          // way to replace next

  logic [4:0]  c_idx;
  logic [22:0] c_tag;
  logic [1:0]  c_w;
  logic        h0, h1, c_fill_way;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_word(a);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_store.exists(a) ? mem_store[a] : init_word(a);
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Cache array read side: combinational on cache_addr.
  always_comb begin
    c_idx = bus.cache_addr[8:4];
    c_tag = bus.cache_addr[31:9];
    c_w   = bus.cache_addr[3:2];
    h0    = cval[c_idx][0] && (ctag[c_idx][0] == c_tag);
    h1    = cval[c_idx][1] && (ctag[c_idx][1] == c_tag);
    c_fill_way = h1 ? 1'b1 : (h0 ? 1'b0 : clru[c_idx]);
    bus.cache_hit   = h0 | h1;
    bus.cache_dout  = h0 ? cdata[c_idx][0][c_w] : (h1 ? cdata[c_idx][1][c_w] : 32'h0);
    bus.cache_valid = cval[c_idx][clru[c_idx]];
    bus.cache_dirty = cdirty[c_idx][clru[c_idx]];
    bus.cache_tag   = ctag[c_idx][clru[c_idx]];
  end

  // Cache array write side on the falling edge; cleared by system reset.
  always @(negedge clk) begin
    if (!rst) begin
      for (int s = 0; s < 32; s++) begin
        cval[s][0] <= 1'b0; cval[s][1] <= 1'b0;
        cdirty[s][0] <= 1'b0; cdirty[s][1] <= 1'b0;
        ctag[s][0] <= '0; ctag[s][1] <= '0;
        clru[s] <= 1'b0;
      end
    end else if (bus.cache_store) begin
      cdata[c_idx][c_fill_way][c_w] <= bus.cache_din;
      clru[c_idx] <= ~c_fill_way;
      if (!(h0 || h1)) begin
        ctag[c_idx][c_fill_way]   <= c_tag;
        cval[c_idx][c_fill_way]   <= 1'b1;
        cdirty[c_idx][c_fill_way] <= 1'b0;
      end
    end else if (bus.cache_edit && (h0 || h1)) begin
      cdata[c_idx][c_fill_way][c_w] <= bus.cache_din;
      cdirty[c_idx][c_fill_way]     <= 1'b1;
      clru[c_idx]                   <= ~c_fill_way;
    end
  end

  // Memory: acks each word after 1..3 cycles of mem_cs, updated just after the edge.
  initial begin
    int m_cnt;
    int m_lat;
    m_cnt = 0;
    m_lat = 1;
    bus.mem_ack = 1'b0;
    bus.mem_din = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rst && bus.mem_cs) begin
        if (m_cnt == 0) m_lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3));
        m_cnt++;
        if (m_cnt == m_lat) begin
          bus.mem_ack = 1'b1;
          lat_sum += m_lat;
          n_acks++;
          m_cnt = 0;
          if (bus.mem_we) mem_store[bus.mem_addr] = bus.mem_dout;
          else            bus.mem_din = mem_rd(bus.mem_addr);
        end else begin
          bus.mem_ack = 1'b0;
          bus.mem_din = $urandom;
        end
      end else begin
        bus.mem_ack = 1'b0;
        m_cnt = 0;
      end
    end
  end

  // Reference: predicts memory traffic and read data for one access; returns miss.
  function automatic bit predict(input bit we, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] line;
    logic [31:0] victim;
    int s;
    int pos;
    bit miss;
    line = {a[31:4], 4'b0000};
    s    = int'(a[8:4]);
    pos  = -1;
    for (int i = 0; i < res[s].size(); i++) if (res[s][i] == line) pos = i;
    miss = (pos < 0);
    if (miss) begin
      if (res[s].size() == 2) begin
        victim = res[s][1];
        if (ldirty[victim])
          for (int i = 0; i < 4; i++)
            exp_mem.push_back('{1'b1, victim + 32'(4 * i), gold_rd(victim + 32'(4 * i))});
        ldirty.delete(victim);
        void'(res[s].pop_back());
      end
      for (int i = 0; i < 4; i++) exp_mem.push_back('{1'b0, line + 32'(4 * i), 32'h0});
      res[s].push_front(line);
      ldirty[line] = 1'b0;
    end
    if (we) begin
      gold[a] = d;
      ldirty[line] = 1'b1;
      if (pos > 0) begin
        res[s].delete(pos);
        res[s].push_front(line);
      end
    end else begin
      exp_rd.push_back(gold_rd(a));
    end
    return miss;
  endfunction

  // CPU driver: call at posedge+1; returns at posedge+1 with cpu_req low.
  task automatic do_access(input bit we, input logic [31:0] a, input logic [31:0] d);
    bit miss;
    int n;
    if (abort) return;
    miss = predict(we, a, d);
    lat_sum = 0;
    bus.cpu_req     = 1'b1;
    bus.cpu_wen     = we;
    bus.cpu_addr    = a;
    bus.cpu_din     = d;
    bus.cpu_u_b_h_w = 3'b010;
    n = 0;
    forever begin
      #3;
      if (!bus.cpu_stall) break;
      n++;
      if (n > 200) begin
        check("access_timeout", 32'(n), 32'd0);
        abort = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!abort) check(miss ? "miss_stall_cycles" : "hit_stall_cycles",
                      32'(n), miss ? 32'(lat_sum + 2) : 32'd0);
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
  endtask

  // Monitor: compares DUT outputs against the scoreboard queues.
  initial begin
    mem_txn_t    t;
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #4;
      if (rst && !sb_off) begin
        check("cache_invalid", 32'(bus.cache_invalid), 32'd0);
        if (!bus.cpu_req)
          check("idle_outputs", 32'({bus.cpu_stall, bus.mem_cs, bus.cache_load,
                                     bus.cache_edit, bus.cache_store}), 32'd0);
        check("edit_strobe", 32'(bus.cache_edit),
              32'(bus.cpu_req && bus.cpu_wen && !bus.cpu_stall));
        if (bus.cpu_req && !bus.cpu_stall) begin
          check("hit_cache_addr", bus.cache_addr, bus.cpu_addr);
          if (bus.cpu_wen) begin
            check("edit_din", bus.cache_din, bus.cpu_din);
          end else begin
            check("hit_load", 32'(bus.cache_load), 32'd1);
            if (exp_rd.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
            else begin
              e = exp_rd.pop_front();
              check("rd_data", bus.cpu_dout, e);
            end
          end
        end
        if (bus.mem_cs && bus.mem_ack) begin
          if (exp_mem.size() == 0) check("mem_unexpected", bus.mem_addr, 32'hFFFF_FFFF);
          else begin
            t = exp_mem.pop_front();
            check("mem_we", 32'(bus.mem_we), 32'(t.we));
            check("mem_addr", bus.mem_addr, t.addr);
            if (t.we) begin
              check("wb_data", bus.mem_dout, t.data);
              check("wb_cache_load", 32'(bus.cache_load), 32'd1);
            end else begin
              check("fill_store", 32'(bus.cache_store), 32'd1);
              check("fill_cache_addr", bus.cache_addr, t.addr);
              check("fill_cache_din", bus.cache_din, bus.mem_din);
              check("fill_size", 32'(bus.cache_u_b_h_w), 32'(3'b010));
            end
          end
        end else begin
          check("store_idle", 32'(bus.cache_store), 32'd0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  tg, ix, w;
    int base;
    int k;

    // Reset held with a request pending: everything quiet.
    bus.cpu_req     = 1'b1;
    bus.cpu_wen     = 1'b0;
    bus.cpu_addr    = 32'h20;
    bus.cpu_din     = 32'h0;
    bus.cpu_u_b_h_w = 3'b010;
    repeat (2) @(posedge clk);
    #4;
    check("rst_stall", 32'(bus.cpu_stall), 32'd0);
    check("rst_mem_cs", 32'(bus.mem_cs), 32'd0);
    check("rst_strobes", 32'({bus.cache_load, bus.cache_edit, bus.cache_store,
                             bus.cache_invalid}), 32'd0);
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #3;
    check("post_rst_idle", 32'({bus.cpu_stall, bus.mem_cs}), 32'd0);
    @(posedge clk);
    #1;

    // Directed sequence, 2-cycle memory.
    fixed_lat = 2;
    do_access(1'b0, 32'h020, 32'h0);          // clean miss, empty cache
    do_access(1'b0, 32'h024, 32'h0);          // hit
    do_access(1'b1, 32'h204, 32'h4444_4444);  // write miss, allocate
    do_access(1'b0, 32'h204, 32'h0);          // reads back written word
    do_access(1'b0, 32'h000, 32'h0);          // fill other way of set 0
    do_access(1'b0, 32'h404, 32'h0);          // evicts dirty line 0x200

    // Random traffic over 4 tags x 4 sets, random latency.
    fixed_lat = 0;
    for (int i = 0; i < 80; i++) begin
      tg = 2'($urandom_range(0, 3));
      ix = 2'($urandom_range(0, 3));
      w  = 2'($urandom_range(0, 3));
      a  = {21'h0, tg, 3'b000, ix, w, 2'b00};
      do_access(1'($urandom_range(0, 1)), a, $urandom);
    end

    // Reset during the refill of word 2.
    if (!abort) begin
      sb_off = 1'b1;
      fixed_lat = 3;
      base = n_acks;
      bus.cpu_req  = 1'b1;
      bus.cpu_wen  = 1'b0;
      bus.cpu_addr = 32'h7F0;
      k = 0;
      while ((n_acks - base) < 2 && k < 100) begin
        @(posedge clk);
        #2;
        k++;
      end
      @(posedge clk);
      #2;
      check("rst_fill_word2_cs", 32'(bus.mem_cs), 32'd1);
      check("rst_fill_word2_addr", bus.mem_addr, 32'h7F8);
      rst = 1'b0;
      #1;
      check("rst_async_mem_cs", 32'(bus.mem_cs), 32'd0);
      check("rst_async_stall", 32'(bus.cpu_stall), 32'd0);
      check("rst_async_store", 32'(bus.cache_store), 32'd0);
      bus.cpu_req = 1'b0;
      repeat (2) @(posedge clk);
      for (int s = 0; s < 32; s++) res[s].delete();
      ldirty.delete();
      gold = mem_store;
      exp_mem.delete();
      exp_rd.delete();
      #1;
      rst = 1'b1;
      sb_off = 1'b0;
      fixed_lat = 2;
      @(posedge clk);
      #1;
      do_access(1'b0, 32'h000, 32'h0);        // fresh miss from word 0
    end

    repeat (3) @(posedge clk);
    check("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
    check("exp_rd_drained", 32'(exp_rd.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_cmu.md
Name: cache_cmu

Overview:
Cache management unit between the CPU data port and the 2-way set-associative data cache (23-bit tag, addr[31:9]; index addr[8:4]; 4-word lines). It serves hits in one cycle. On a miss it stalls the CPU, writes back a dirty victim line word by word, refills the line from memory through a req/ack handshake, then replays the access. Write policy: write-back, write-allocate.

Parameters:
ADDR_WIDTH, 32, byte address width
TAG_WIDTH, 23, cache tag width (addr[31:9])
LINE_WORDS, 4, 32-bit words per line
OFFSET_BITS, 4, byte offset bits within a line

Ports:
clk  in  1  system clock; CMU state updates on rising edge
rst  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request
cpu_wen  in  1  1 = write, 0 = read
cpu_u_b_h_w  in  3  size/sign code, passed to cache
cpu_addr  in  32  byte address
cpu_din  in  32  write data
cpu_dout  out  32  read data (cache_dout passthrough)
cpu_stall  out  1  CPU must hold request stable
cache_addr  out  32  cache address
cache_load  out  1  cache read strobe
cache_edit  out  1  cache write-hit strobe (sets dirty)
cache_store  out  1  cache line-fill word write (auto-replaces LRU way)
cache_invalid  out  1  tied 0 in this revision
cache_u_b_h_w  out  3  size code to cache
cache_din  out  32  data to cache
cache_hit  in  1  cache hit
cache_dout  in  32  cache read data
cache_valid  in  1  victim-line valid
cache_dirty  in  1  victim-line dirty
cache_tag  in  23  victim-line tag
mem_cs  out  1  memory request
mem_we  out  1  memory write
mem_addr  out  32  word-aligned memory address
mem_dout  out  32  write-back data
mem_din  in  32  refill data
mem_ack  in  1  memory word complete

Behaviour:
- Cache is clocked on the opposite edge; its hit/dout/valid/dirty/tag are combinationally valid within the same clk cycle.
- Reset (rst=0, async): state=S_IDLE; word_cnt=0; all outputs 0 (cpu_stall=0, mem_cs=0, all cache strobes 0).
- States:
  - S_IDLE, no request: all strobes 0, cpu_stall=0.
  - S_IDLE, request: cache_addr=cpu_addr, cache_u_b_h_w=cpu_u_b_h_w; cache_load=~cpu_wen; cache_edit=cpu_wen&cache_hit; cache_din=cpu_din.
  - S_IDLE, hit: cpu_stall=0 in the same cycle (0-cycle latency); state is held.
  - S_IDLE, miss: cpu_stall=1. Latch req_addr and victim_tag=cache_tag.
    - cache_valid & cache_dirty -> S_BACK.
    - otherwise -> S_FILL.
  - S_BACK: word i=word_cnt; vaddr = {victim_tag, req_addr[8:4], i, 2'b00}.
    - cache_addr=vaddr, cache_load=1, cache_u_b_h_w=3'b010.
    - mem_cs=1, mem_we=1, mem_addr=vaddr, mem_dout=cache_dout.
    - On mem_ack: word_cnt++. On ack of the last word: word_cnt=0 -> S_FILL.
  - S_FILL: faddr = {req_addr[31:4], i, 2'b00}; mem_cs=1, mem_we=0, mem_addr=faddr.
    - On mem_ack: cache_store=1, cache_addr=faddr, cache_din=mem_din, cache_u_b_h_w=3'b010 (combinational, same cycle); word_cnt++.
    - On ack of the last word: word_cnt=0 -> S_WAIT.
  - S_WAIT: one cycle, no strobes, cpu_stall=1 -> S_IDLE. The replayed access then hits and cpu_stall drops.
- cpu_stall=1 in S_BACK, S_FILL and S_WAIT.
- Each word takes at least 1 cycle; mem_ack is sampled only while mem_cs=1, otherwise ignored. mem_cs and mem_addr stay stable until ack.
- word_cnt is log2(LINE_WORDS) bits and wraps to 0 exactly on the last ack.
- Miss with cache_valid=0 or a clean victim: no write-back.
- A change of cpu_addr during a stall is a protocol violation; the CMU uses latched req_addr.
- rst=0 mid-transfer: mem_cs drops immediately, state returns to S_IDLE, the partial line is abandoned.

Decomposition:
- Package cache_pkg holds:
  - state enum S_IDLE/S_BACK/S_FILL/S_WAIT;
  - u_b_h_w encodings (word = 3'b010);
  - LINE_WORDS, TAG_WIDTH and index/offset bit positions, shared with the cache.
- No sub-module: single FSM plus word counter.

Test Plan:
- Reset: rst=0 with cpu_req=1 -> cpu_stall=0, mem_cs=0, no strobes; after release, state S_IDLE.
- Clean read miss at 0x020, cache empty, ack after 2 cycles per word:
  - mem reads 0x020, 0x024, 0x028, 0x02C with cache_store on each ack;
  - one S_WAIT cycle, then hit, cpu_dout = mem word 0x020, cpu_stall=0.
- Read hit 0x024 -> cpu_stall=0 in the same cycle, mem_cs never asserted.
- Write miss 0x204, din 0x44444444 -> fill 0x200–0x20C, then cache_edit on replay; read of 0x204 returns 0x44444444.
- Dirty eviction: set 0 holds tag 0 (recent) and tag 1 (dirty); read 0x404 ->
  - S_BACK writes 0x200–0x20C with mem_we=1, mem_dout at 0x204 = 0x44444444;
  - then S_FILL reads 0x400–0x40C.
- rst=0 asserted during S_FILL word 2 -> mem_cs=0 asynchronously; after release, a new read of 0x000 starts a fresh miss with word_cnt=0.
